// File: rtl/data_mem_param.sv
// Parametrised data memory: MEM-field driven write/read/clear, pipelined read path
// with a valid strobe, and a clear sequencer that zeroes the array after reset or on command.
module data_mem_param #(
  parameter int WORD_SIZE      = 4,
  parameter int ADDR_WIDTH     = 4,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            mem_op,
  input  logic [WORD_SIZE-1:0]  bus_in,
  output logic [WORD_SIZE-1:0]  bus_out,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
    $error("data_mem_param: READ_LATENCY must be 1..3");
  end

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    SWEEP      = 2'd1,
    READY      = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [WORD_SIZE-1:0]    memory [DEPTH];
  logic [WORD_SIZE-1:0]    pipe_d [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_v;
  logic                    rd_issue;
  logic                    wr_issue;
  logic                    clr_issue;

  // Ops only take effect in READY; reset low overrides everything.
  always_comb begin
    state_nx  = state;
    rd_issue  = 1'b0;
    wr_issue  = 1'b0;
    clr_issue = 1'b0;
    case (state)
      RESET_HOLD: state_nx = (CLEAR_ON_RESET != 0) ? SWEEP : READY;
      SWEEP:      if (&cnt) state_nx = READY;
      READY: begin
        case (mem_op)
          OP_WRITE: wr_issue  = 1'b1;
          OP_READ:  rd_issue  = 1'b1;
          OP_CLEAR: clr_issue = 1'b1;
          OP_NOP:   ;
          default:  ;
        endcase
        if (clr_issue) state_nx = SWEEP;
      end
      default:    state_nx = RESET_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= RESET_HOLD;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset)               cnt <= '0;
    else if (state == SWEEP)  cnt <= cnt + 1'b1;
    else if (clr_issue)       cnt <= '0;
  end

  // Array has no reset: contents survive reset, only the sweep zeroes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == SWEEP)  memory[cnt]  <= '0;
      else if (wr_issue)   memory[addr] <= bus_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= rd_issue;
      for (int i = 1; i < READ_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_issue) pipe_d[0] <= memory[addr];
    for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] <= pipe_d[i-1];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_out  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pipe_v[READ_LATENCY-1];
      if (pipe_v[READ_LATENCY-1]) bus_out <= pipe_d[READ_LATENCY-1];
    end
  end

  assign busy = (state == SWEEP);

endmodule

// File: tb/tb_data_mem_param.sv
// Bench for data_mem_param: three clear-on-reset instances (latency 1/2/3) share stimulus
// against a reference memory model; a fourth instance without clear-on-reset runs separately.
module tb_data_mem_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] addr;
  logic [1:0] mem_op;
  logic [3:0] bus_in;
  logic [3:0] bo [3];
  logic       rv [3];
  logic       bz [3];

  logic       reset_nc;
  logic [1:0] mem_op_nc;
  logic [3:0] bo_nc;
  logic       rv_nc;
  logic       bz_nc;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  // Reference model of the shared instances
  typedef enum int {M_HOLD, M_SWEEP, M_READY} m_state_t;
  m_state_t   m_state = M_HOLD;
  int         m_cnt   = 0;
  logic [3:0] m_mem [16];
  logic [3:0] exp_q [3][$];
  int         due_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_param #(.WORD_SIZE(4), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_l1 (
    .clk(clk), .reset(reset), .addr(addr), .mem_op(mem_op), .bus_in(bus_in),
    .bus_out(bo[0]), .rd_valid(rv[0]), .busy(bz[0]));
  data_mem_param #(.WORD_SIZE(4), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_l2 (
    .clk(clk), .reset(reset), .addr(addr), .mem_op(mem_op), .bus_in(bus_in),
    .bus_out(bo[1]), .rd_valid(rv[1]), .busy(bz[1]));
  data_mem_param #(.WORD_SIZE(4), .ADDR_WIDTH(4), .READ_LATENCY(3), .CLEAR_ON_RESET(1)) u_l3 (
    .clk(clk), .reset(reset), .addr(addr), .mem_op(mem_op), .bus_in(bus_in),
    .bus_out(bo[2]), .rd_valid(rv[2]), .busy(bz[2]));
  data_mem_param #(.WORD_SIZE(4), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) u_nc (
    .clk(clk), .reset(reset_nc), .addr(addr), .mem_op(mem_op_nc), .bus_in(bus_in),
    .bus_out(bo_nc), .rd_valid(rv_nc), .busy(bz_nc));

  // Drive one cycle on the shared instances and advance the model past that edge.
  task automatic step(input logic rst, input logic [1:0] op, input logic [3:0] a, input logic [3:0] d);
    reset = rst; mem_op = op; addr = a; bus_in = d;
    @(posedge clk); #1;
    if (!rst) begin
      m_state = M_HOLD; m_cnt = 0;
      for (int k = 0; k < 3; k++) begin exp_q[k].delete(); due_q[k].delete(); end
    end else begin
      case (m_state)
        M_HOLD:  begin m_state = M_SWEEP; m_cnt = 0; end
        M_SWEEP: begin
          m_mem[m_cnt] = 4'h0;
          if (m_cnt == 15) m_state = M_READY;
          m_cnt = (m_cnt + 1) % 16;
        end
        default: begin
          case (op)
            2'b01: m_mem[a] = d;
            2'b10: for (int k = 0; k < 3; k++) begin
              exp_q[k].push_back(m_mem[a]);
              due_q[k].push_back(cyc + k + 1);
            end
            2'b11: begin m_state = M_SWEEP; m_cnt = 0; end
            default: ;
          endcase
        end
      endcase
    end
  endtask

  // Scoreboard: busy every cycle, read results matched in order and on their due cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (bz[k] !== (m_state == M_SWEEP)) begin
          n_fail++;
          $display("FAIL busy_l%0d cyc=%0d got=%b exp=%b", k+1, cyc, bz[k], (m_state == M_SWEEP));
        end
        if (rv[k] === 1'b1) begin
          n_tests++;
          if (exp_q[k].size() == 0) begin
            n_fail++;
            $display("FAIL spurious_rd_valid_l%0d cyc=%0d bus_out=%h", k+1, cyc, bo[k]);
          end else begin
            logic [3:0] e;
            int         due;
            e   = exp_q[k].pop_front();
            due = due_q[k].pop_front();
            if (bo[k] !== e || due != cyc) begin
              n_fail++;
              $display("FAIL read_l%0d cyc=%0d got=%h exp=%h due_cyc=%0d", k+1, cyc, bo[k], e, due);
            end
          end
        end else if (rv[k] !== 1'b0) begin
          n_tests++; n_fail++;
          $display("FAIL rd_valid_x_l%0d cyc=%0d got=%b exp=0/1", k+1, cyc, rv[k]);
        end else if (due_q[k].size() > 0 && due_q[k][0] <= cyc) begin
          n_tests++; n_fail++;
          $display("FAIL missing_read_l%0d cyc=%0d got=no rd_valid exp=%h", k+1, cyc, exp_q[k][0]);
          void'(exp_q[k].pop_front());
          void'(due_q[k].pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (bz[k] !== 1'b0 || bo[k] !== 4'h0 || rv[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_l%0d got busy=%b bus_out=%h rd_valid=%b exp 0/0/0", tag, k+1, bz[k], bo[k], rv[k]);
      end
    end
  endtask

  task automatic wait_sweep(input string tag, input int write_at);
    int n = 0;
    while (bz[0] === 1'b1 && n < 40) begin
      n++;
      if (n == write_at) step(1'b1, 2'b01, 4'd7, 4'hF);
      else               step(1'b1, 2'b00, 4'd0, 4'h0);
    end
    n_tests++;
    if (n != 16) begin
      n_fail++;
      $display("FAIL %s_busy_cycles got=%0d exp=16", tag, n);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 2'b00, 4'd0, 4'h0);
  endtask

  task automatic test_reset;
    reset_nc = 1'b0; mem_op_nc = 2'b00;
    step(1'b0, 2'b00, 4'd0, 4'h0);
    step(1'b0, 2'b10, 4'd3, 4'h0);
    mon_en = 1'b1;
    check_reset_outputs("reset_hold");
    n_tests++;
    if (bz_nc !== 1'b0 || bo_nc !== 4'h0 || rv_nc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold_nc got busy=%b bus_out=%h rd_valid=%b exp 0/0/0", bz_nc, bo_nc, rv_nc);
    end
  endtask

  task automatic test_no_clear;
    reset_nc = 1'b1; mem_op_nc = 2'b00;
    step(1'b0, 2'b00, 4'd0, 4'h0);
    mem_op_nc = 2'b01; step(1'b0, 2'b00, 4'd15, 4'hF);
    mem_op_nc = 2'b10; step(1'b0, 2'b00, 4'd15, 4'h0);
    mem_op_nc = 2'b00; step(1'b0, 2'b00, 4'd0, 4'h0);
    n_tests++;
    if (rv_nc !== 1'b1 || bo_nc !== 4'hF) begin
      n_fail++;
      $display("FAIL nc_read got rd_valid=%b bus_out=%h exp 1/f", rv_nc, bo_nc);
    end
    step(1'b0, 2'b00, 4'd0, 4'h0);
    n_tests++;
    if (rv_nc !== 1'b0 || bo_nc !== 4'hF) begin
      n_fail++;
      $display("FAIL nc_hold got rd_valid=%b bus_out=%h exp 0/f", rv_nc, bo_nc);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 2'b00, 4'd0, 4'h0);
      n_tests++;
      if (bz_nc !== 1'b0) begin
        n_fail++;
        $display("FAIL nc_busy cyc=%0d got=%b exp=0", cyc, bz_nc);
      end
    end
  endtask

  task automatic test_reset_sweep;
    step(1'b1, 2'b00, 4'd0, 4'h0);
    wait_sweep("reset_sweep", 0);
    for (int i = 0; i < 16; i++) step(1'b1, 2'b10, 4'(i), 4'h0);
    drain(4);
  endtask

  task automatic test_write_read;
    step(1'b1, 2'b01, 4'd5, 4'hA);
    step(1'b1, 2'b10, 4'd5, 4'h0);
    step(1'b1, 2'b00, 4'd0, 4'h0);
    n_tests++;
    if (rv[0] !== 1'b1 || bo[0] !== 4'hA || rv[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rd_lat1 got rd_valid=%b bus_out=%h l3_rd_valid=%b exp 1/a/0", rv[0], bo[0], rv[2]);
    end
    drain(2);
    n_tests++;
    if (rv[2] !== 1'b1 || bo[2] !== 4'hA) begin
      n_fail++;
      $display("FAIL wr_rd_lat3 got rd_valid=%b bus_out=%h exp 1/a", rv[2], bo[2]);
    end
    drain(2);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (bo[k] !== 4'hA || rv[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_rd_hold_l%0d got bus_out=%h rd_valid=%b exp a/0", k+1, bo[k], rv[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int hits = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 4'(i), 4'(i + 1));
    for (int i = 0; i < 7; i++) begin
      if (i < 4) step(1'b1, 2'b10, 4'(i), 4'h0);
      else       step(1'b1, 2'b00, 4'd0, 4'h0);
      if (rv[1] === 1'b1) hits++;
    end
    n_tests++;
    if (hits != 4) begin
      n_fail++;
      $display("FAIL stream_rd_valid_count got=%0d exp=4", hits);
    end
    drain(2);
  endtask

  task automatic test_clear_inflight;
    step(1'b1, 2'b01, 4'd7, 4'h6);
    step(1'b1, 2'b10, 4'd7, 4'h0);
    step(1'b1, 2'b11, 4'd0, 4'h0);
    wait_sweep("clear_sweep", 3);
    step(1'b1, 2'b10, 4'd7, 4'h0);
    drain(4);
    n_tests++;
    if (bo[2] !== 4'h0) begin
      n_fail++;
      $display("FAIL clear_read7 got=%h exp=0", bo[2]);
    end
  endtask

  task automatic test_reset_mid_sweep;
    step(1'b1, 2'b01, 4'd2, 4'h9);
    step(1'b1, 2'b10, 4'd2, 4'h0);
    drain(4);
    step(1'b1, 2'b11, 4'd0, 4'h0);
    drain(7);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b10, 4'd2, 4'h0);
      check_reset_outputs("mid_sweep_reset");
    end
    step(1'b1, 2'b00, 4'd0, 4'h0);
    wait_sweep("resweep", 0);
  endtask

  task automatic test_reset_mid_read;
    step(1'b1, 2'b01, 4'd4, 4'hC);
    step(1'b1, 2'b10, 4'd4, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, 4'd0, 4'h0);
      check_reset_outputs("mid_read_reset");
    end
    step(1'b1, 2'b00, 4'd0, 4'h0);
    wait_sweep("read_resweep", 0);
    step(1'b1, 2'b10, 4'd4, 4'h0);
    step(1'b1, 2'b10, 4'd2, 4'h0);
    drain(5);
  endtask

  initial begin
    reset = 1'b0; mem_op = 2'b00; addr = 4'd0; bus_in = 4'h0;
    reset_nc = 1'b0; mem_op_nc = 2'b00;
    test_reset;
    test_no_clear;
    test_reset_sweep;
    test_write_read;
    test_back_to_back;
    test_clear_inflight;
    test_reset_mid_sweep;
    test_reset_mid_read;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (exp_q[k].size() != 0) begin
        n_fail++;
        $display("FAIL leftover_reads_l%0d got=%0d exp=0", k+1, exp_q[k].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
